lsu_data_memory: RTL and testbench
==================================

# lsu_data_memory

Parametrised byte-addressable data memory for the RISC-V core. It executes RV32I load/store sizes (byte, half, word), applies byte-lane write masks and load sign or zero extension, and flags misaligned or illegal accesses. It clears its contents after reset and accepts one request per cycle with a fixed one-cycle response. It sits behind the MEM stage and replaces the flat word-only memory.

## Interface
- ADDR_W, 13: byte-address width. Depth is DEPTH = 2**(ADDR_W-2) 32-bit words. Minimum value is 4.
- INIT_CLEAR, 1: 1 = zero every word after reset; 0 = skip the clear (contents undefined after power-up, kept across reset).
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  request valid.
- i_we  in  1  1 = store, 0 = load. Sampled with i_req.
- i_funct3  in  3  RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_ready  out  1  block accepts a request this cycle.
- o_rvalid  out  1  load response valid (one-cycle pulse).
- o_rdata  out  32  extended load data.
- o_err  out  1  access error for the request accepted in the previous cycle (one-cycle pulse).

## Operation
- FSM states:
  - RESET: while i_rst = 1.
  - INIT: clear sweep; only entered when INIT_CLEAR = 1.
  - RUN
- Transitions:
  - RESET -> INIT when INIT_CLEAR = 1, otherwise RESET -> RUN.
  - INIT -> RUN after word DEPTH-1 is written.
  - i_rst = 1 in any state -> RESET.
- INIT:
  - A word counter starts at 0 and writes 32'h0 to one word per cycle.
  - o_ready = 0 throughout. i_req is ignored, not queued.
- RUN:
  - o_ready = 1.
  - A request is accepted in every cycle where i_req & o_ready.
- Legal encodings:
  - Stores: funct3 000, 001, 010.
  - Loads: funct3 000, 001, 010, 100, 101.
  - Any other funct3 is illegal.
- Misaligned accesses:
  - Half-word access with i_addr[0] = 1.
  - Word access with i_addr[1:0] != 0.
- Word index = i_addr[ADDR_W-1:2]. Lane = i_addr[1:0].
- Store byte: writes i_wdata[7:0] into lane i_addr[1:0] only.
- Store half: writes i_wdata[15:0] into lanes {i_addr[1],0} and {i_addr[1],1}.
- Store word: writes all four lanes.
- Unwritten lanes keep their old value.
- Load: selects a byte or half from the addressed lane. B and H sign-extend; BU and HU zero-extend; W returns the whole word.
- Error handling (illegal or misaligned request):
  - No memory write.
  - o_err = 1 in the next cycle.
  - For a load, o_rvalid = 1 with o_rdata = 0.
  - For a store, o_rvalid = 0.
- Memory write and read use the same port.
  - A load accepted in the cycle after a store to the same word returns the stored data.
  - No forwarding is needed inside one cycle because only one request is accepted per cycle.
- Reset mid-operation:
  - A pending response is dropped.
  - With INIT_CLEAR = 1, the sweep restarts at word 0.
  - A store accepted in the same cycle that i_rst = 1 is not performed.

## Timing
- Reset values, in the cycle after any edge with i_rst = 1: o_ready = 0, o_rvalid = 0, o_err = 0, o_rdata = 32'h0.
- Cycle 0 is the first cycle with i_rst = 0.
  - INIT_CLEAR = 1: word k is cleared at the end of cycle k; o_ready = 1 from cycle DEPTH.
  - INIT_CLEAR = 0: o_ready = 1 from cycle 1.
- Load latency is 1 cycle. A load accepted in cycle N gives o_rvalid = 1 and o_rdata valid in cycle N+1.
- o_rdata holds its value until the next load response.
- Store latency: the write completes at the end of acceptance cycle N. An error is reported in cycle N+1.
- Throughput: one request per cycle, with no bubbles between back-to-back loads or stores.
- All outputs are registered except o_ready, which is decoded from the FSM state register.

## Test plan
Use ADDR_W = 6 (DEPTH = 16) and INIT_CLEAR = 1 unless noted.
- Reset release:
  - o_ready = 0 for cycles 0..15 and 1 in cycle 16.
  - LW at every address 0x00..0x3C returns 32'h0.
- Sub-word stores and loads:
  - SW 0x10 = 32'hA5A5A5A5, then SB 0x11 = 8'h7F, then SH 0x12 = 16'h8001.
  - LW 0x10 -> 32'h80017FA5.
  - LB 0x10 -> 32'hFFFFFFA5; LBU 0x10 -> 32'h000000A5.
  - LH 0x12 -> 32'hFFFF8001; LHU 0x12 -> 32'h00008001.
- Back-to-back RAW: SW 0x3C = 32'hDEADBEEF in cycle N, LW 0x3C in cycle N+1 -> o_rvalid in N+2 with 32'hDEADBEEF.
- Errors:
  - SW 0x21 (misaligned) -> o_err pulse and memory unchanged; a following LW 0x20 returns the prior value.
  - LH 0x03 -> o_err = 1, o_rvalid = 1, o_rdata = 0.
  - funct3 011 -> o_err = 1.
- Reset mid-sweep: assert i_rst in cycle 5 of INIT and release it. The sweep restarts and o_ready rises exactly 16 cycles after the release.
- INIT_CLEAR = 0: o_ready = 1 in cycle 1. A word written before reset reads back unchanged after reset.

Source files
------------

// File: rtl/lsu_data_memory.sv
// Byte-addressable RV32I data memory: B/H/W stores with lane masks, sign/zero-extended loads,
// illegal/misaligned detection, optional clear sweep after reset, one request per cycle.
module lsu_data_memory #(
   parameter int ADDR_W     = 13,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [2:0]        i_funct3,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_ready,
   output logic              o_rvalid,
   output logic [31:0]       o_rdata,
   output logic              o_err
);
   localparam int WORD_W = ADDR_W - 2;
   localparam int DEPTH  = 2**WORD_W;
   localparam logic [WORD_W-1:0] LAST_WORD = {WORD_W{1'b1}};

   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [WORD_W-1:0]   r_clr_idx;
   logic                w_clr_en;

   logic                w_legal;
   logic                w_misalign;
   logic                w_bad;
   logic                w_acc;
   logic                w_store;
   logic                w_load;
   logic [3:0]          w_req_be;
   logic [31:0]         w_req_wdata;

   logic [WORD_W-1:0]   w_mem_idx;
   logic                w_mem_we;
   logic [3:0]          w_mem_be;
   logic [31:0]         w_mem_wdata;
   logic [31:0]         w_rd_word;

   logic                r_rvalid;
   logic                r_err;
   logic [2:0]          r_ld_f3;
   logic [1:0]          r_ld_lane;
   logic                r_ld_zero;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_RESET;
         r_clr_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_clr_en) r_clr_idx <= r_clr_idx + 1'b1;
      end
   end

   // Word 0 is cleared in the release cycle itself so word k is cleared at the end of cycle k.
   always_comb begin
      w_state_next = r_state;
      w_clr_en     = 1'b0;
      case (r_state)
         ST_RESET: begin
            if (INIT_CLEAR) begin
               w_clr_en     = 1'b1;
               w_state_next = ST_INIT;
            end else begin
               w_state_next = ST_RUN;
            end
         end
         ST_INIT: begin
            w_clr_en = 1'b1;
            if (r_clr_idx == LAST_WORD) w_state_next = ST_RUN;
         end
         ST_RUN:  w_state_next = ST_RUN;
         default: w_state_next = ST_RESET;
      endcase
      if (i_rst) w_clr_en = 1'b0;
   end

   assign o_ready = (r_state == ST_RUN);

   always_comb begin
      w_legal = 1'b0;
      case (i_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = ~i_we;
         default:                w_legal = 1'b0;
      endcase
      w_misalign = 1'b0;
      if (i_funct3[1:0] == 2'b01)      w_misalign = i_addr[0];
      else if (i_funct3[1:0] == 2'b10) w_misalign = |i_addr[1:0];
   end

   assign w_bad   = ~w_legal | w_misalign;
   assign w_acc   = i_req & o_ready & ~i_rst;
   assign w_store = w_acc & i_we & ~w_bad;
   assign w_load  = w_acc & ~i_we & ~w_bad;

   // Store data is replicated across lanes so each lane simply takes its own byte.
   always_comb begin
      w_req_be    = 4'b1111;
      w_req_wdata = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            w_req_be    = 4'b0001 << i_addr[1:0];
            w_req_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_req_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_req_wdata = {2{i_wdata[15:0]}};
         end
         default: begin
            w_req_be    = 4'b1111;
            w_req_wdata = i_wdata;
         end
      endcase
   end

   assign w_mem_idx   = w_clr_en ? r_clr_idx : i_addr[ADDR_W-1:2];
   assign w_mem_we    = w_clr_en | w_store;
   assign w_mem_be    = w_clr_en ? 4'b1111 : w_req_be;
   assign w_mem_wdata = w_clr_en ? 32'h0 : w_req_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_mem [DEPTH];
         logic [7:0] r_rd;

         always_ff @(posedge i_clk) begin
            if (w_mem_we && w_mem_be[gi]) r_mem[w_mem_idx] <= w_mem_wdata[gi*8 +: 8];
            if (i_rst)       r_rd <= '0;
            else if (w_load) r_rd <= r_mem[w_mem_idx];
         end

         assign w_rd_word[gi*8 +: 8] = r_rd;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_ld_f3   <= '0;
         r_ld_lane <= '0;
         r_ld_zero <= 1'b0;
      end else begin
         r_rvalid <= w_acc & ~i_we;
         r_err    <= w_acc & w_bad;
         if (w_acc && !i_we) begin
            r_ld_f3   <= i_funct3;
            r_ld_lane <= i_addr[1:0];
            r_ld_zero <= w_bad;
         end
      end
   end

   assign w_byte = w_rd_word[{r_ld_lane, 3'b000} +: 8];
   assign w_half = r_ld_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      case (r_ld_f3)
         3'b000:  o_rdata = {{24{w_byte[7]}}, w_byte};
         3'b100:  o_rdata = {24'h0, w_byte};
         3'b001:  o_rdata = {{16{w_half[15]}}, w_half};
         3'b101:  o_rdata = {16'h0, w_half};
         default: o_rdata = w_rd_word;
      endcase
      if (r_ld_zero) o_rdata = 32'h0;
   end

   assign o_rvalid = r_rvalid;
   assign o_err    = r_err;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench for lsu_data_memory: a clearing instance (ADDR_W=6) driven from a vector table
// plus hand sequences, and a non-clearing instance sharing the request bus.
module tb_lsu_data_memory;
   logic        clk = 1'b0;
   logic        rst;
   logic        rst0;
   logic        req;
   logic        we;
   logic [2:0]  f3;
   logic [5:0]  addr;
   logic [31:0] wdata;
   logic        ready, rvalid, err;
   logic [31:0] rdata;
   logic        ready0, rvalid0, err0;
   logic [31:0] rdata0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_data_memory #(.ADDR_W(6), .INIT_CLEAR(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(f3),
      .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_rvalid(rvalid),
      .o_rdata(rdata), .o_err(err)
   );

   lsu_data_memory #(.ADDR_W(6), .INIT_CLEAR(1'b0)) dut0 (
      .i_clk(clk), .i_rst(rst0), .i_req(req), .i_we(we), .i_funct3(f3),
      .i_addr(addr), .i_wdata(wdata), .o_ready(ready0), .o_rvalid(rvalid0),
      .o_rdata(rdata0), .o_err(err0)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic        exp_rvalid;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic w, input logic [2:0] f,
                               input logic [5:0] a, input logic [31:0] d,
                               input logic ev, input logic ee, input logic [31:0] ed);
      vec_t v;
      v.name = n; v.we = w; v.f3 = f; v.addr = a; v.wdata = d;
      v.exp_rvalid = ev; v.exp_err = ee; v.exp_rdata = ed;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [2:0] f, input logic [5:0] a, input logic [31:0] d);
      req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
   endtask

   task automatic apply(input vec_t v);
      drive(v.we, v.f3, v.addr, v.wdata);
      step();
      req = 1'b0;
      $display("[TB] %s we=%0d f3=%03b addr=%02h wdata=%08h -> rvalid=%0d err=%0d rdata=%08h",
               v.name, v.we, v.f3, v.addr, v.wdata, rvalid, err, rdata);
      check({v.name, " rvalid"}, 32'(rvalid), 32'(v.exp_rvalid));
      check({v.name, " err"}, 32'(err), 32'(v.exp_err));
      if (v.exp_rvalid) check({v.name, " rdata"}, rdata, v.exp_rdata);
   endtask

   initial begin
      for (int a = 0; a < 16; a++)
         vecs.push_back(mk("LW init", 1'b0, 3'b010, 6'(a * 4), 32'h0, 1'b1, 1'b0, 32'h0));
      vecs.push_back(mk("SW 10",     1'b1, 3'b010, 6'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mk("SB 11",     1'b1, 3'b000, 6'h11, 32'h0000007F, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mk("SH 12",     1'b1, 3'b001, 6'h12, 32'h00008001, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mk("LW 10",     1'b0, 3'b010, 6'h10, 32'h0, 1'b1, 1'b0, 32'h80017FA5));
      vecs.push_back(mk("LB 10",     1'b0, 3'b000, 6'h10, 32'h0, 1'b1, 1'b0, 32'hFFFFFFA5));
      vecs.push_back(mk("LBU 10",    1'b0, 3'b100, 6'h10, 32'h0, 1'b1, 1'b0, 32'h000000A5));
      vecs.push_back(mk("LH 12",     1'b0, 3'b001, 6'h12, 32'h0, 1'b1, 1'b0, 32'hFFFF8001));
      vecs.push_back(mk("LHU 12",    1'b0, 3'b101, 6'h12, 32'h0, 1'b1, 1'b0, 32'h00008001));
      vecs.push_back(mk("LB 11",     1'b0, 3'b000, 6'h11, 32'h0, 1'b1, 1'b0, 32'h0000007F));
      vecs.push_back(mk("LBU 13",    1'b0, 3'b100, 6'h13, 32'h0, 1'b1, 1'b0, 32'h00000080));
      vecs.push_back(mk("LB 13",     1'b0, 3'b000, 6'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80));
      vecs.push_back(mk("LH 10",     1'b0, 3'b001, 6'h10, 32'h0, 1'b1, 1'b0, 32'h00007FA5));
      vecs.push_back(mk("SW 20",     1'b1, 3'b010, 6'h20, 32'h12345678, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mk("SW 21 mis", 1'b1, 3'b010, 6'h21, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0));
      vecs.push_back(mk("LW 20",     1'b0, 3'b010, 6'h20, 32'h0, 1'b1, 1'b0, 32'h12345678));
      vecs.push_back(mk("LH 03 mis", 1'b0, 3'b001, 6'h03, 32'h0, 1'b1, 1'b1, 32'h0));
      vecs.push_back(mk("LD f3=011", 1'b0, 3'b011, 6'h00, 32'h0, 1'b1, 1'b1, 32'h0));
      vecs.push_back(mk("ST f3=011", 1'b1, 3'b011, 6'h20, 32'h0, 1'b0, 1'b1, 32'h0));
      vecs.push_back(mk("SH 23 mis", 1'b1, 3'b001, 6'h23, 32'h0, 1'b0, 1'b1, 32'h0));
      vecs.push_back(mk("SW 22 mis", 1'b1, 3'b010, 6'h22, 32'h0, 1'b0, 1'b1, 32'h0));
      vecs.push_back(mk("LHU 01 mis",1'b0, 3'b101, 6'h01, 32'h0, 1'b1, 1'b1, 32'h0));
      vecs.push_back(mk("ST f3=100", 1'b1, 3'b100, 6'h20, 32'h0, 1'b0, 1'b1, 32'h0));
      vecs.push_back(mk("LW 20 kept",1'b0, 3'b010, 6'h20, 32'h0, 1'b1, 1'b0, 32'h12345678));
      vecs.push_back(mk("SB 22",     1'b1, 3'b000, 6'h22, 32'h000000EE, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mk("LW 20 sb",  1'b0, 3'b010, 6'h20, 32'h0, 1'b1, 1'b0, 32'h12EE5678));

      rst = 1'b1; rst0 = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b0; addr = '0; wdata = '0;
      step(); step(); step();
      check("reset ready", 32'(ready), 32'd0);
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rdata", rdata, 32'h0);

      // Release both; ready must rise at cycle 16 (clearing) and cycle 1 (non-clearing).
      rst = 1'b0; rst0 = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         $display("[TB] release cycle %0d ready=%0d ready0=%0d", k, ready, ready0);
         check($sformatf("ready cyc%0d", k), 32'(ready), 32'(k == 16));
         check($sformatf("ready0 cyc%0d", k), 32'(ready0), 32'(k >= 1));
         if (k < 16) step();
      end

      foreach (vecs[i]) apply(vecs[i]);

      // Back-to-back store then load to the same word.
      drive(1'b1, 3'b010, 6'h3C, 32'hDEADBEEF);
      step();
      drive(1'b0, 3'b010, 6'h3C, 32'h0);
      $display("[TB] RAW SW 3C -> rvalid=%0d err=%0d", rvalid, err);
      check("RAW store rvalid", 32'(rvalid), 32'd0);
      check("RAW store err", 32'(err), 32'd0);
      step();
      req = 1'b0;
      $display("[TB] RAW LW 3C -> rvalid=%0d rdata=%08h", rvalid, rdata);
      check("RAW rvalid", 32'(rvalid), 32'd1);
      check("RAW rdata", rdata, 32'hDEADBEEF);

      // Back-to-back loads, then o_rdata holds through an idle cycle.
      drive(1'b0, 3'b010, 6'h10, 32'h0);
      step();
      drive(1'b0, 3'b100, 6'h13, 32'h0);
      $display("[TB] B2B LW 10 -> rvalid=%0d rdata=%08h", rvalid, rdata);
      check("B2B1 rvalid", 32'(rvalid), 32'd1);
      check("B2B1 rdata", rdata, 32'h80017FA5);
      step();
      req = 1'b0;
      $display("[TB] B2B LBU 13 -> rvalid=%0d rdata=%08h", rvalid, rdata);
      check("B2B2 rvalid", 32'(rvalid), 32'd1);
      check("B2B2 rdata", rdata, 32'h00000080);
      step();
      $display("[TB] idle -> rvalid=%0d rdata=%08h", rvalid, rdata);
      check("hold rvalid", 32'(rvalid), 32'd0);
      check("hold rdata", rdata, 32'h00000080);

      // Load accepted in a reset cycle is dropped; outputs return to reset values.
      drive(1'b0, 3'b010, 6'h3C, 32'h0);
      rst = 1'b1;
      step();
      req = 1'b0;
      $display("[TB] reset with LW -> ready=%0d rvalid=%0d err=%0d rdata=%08h", ready, rvalid, err, rdata);
      check("rst ready", 32'(ready), 32'd0);
      check("rst rvalid", 32'(rvalid), 32'd0);
      check("rst err", 32'(err), 32'd0);
      check("rst rdata", rdata, 32'h0);

      // Reset in cycle 5 of the sweep; requests during INIT must be ignored.
      rst = 1'b0;
      drive(1'b1, 3'b010, 6'h04, 32'hCAFEF00D);
      for (int k = 0; k < 5; k++) step();
      check("mid-sweep ready", 32'(ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         $display("[TB] restart cycle %0d ready=%0d", k, ready);
         check($sformatf("restart ready cyc%0d", k), 32'(ready), 32'(k == 16));
         if (k < 16) step();
      end
      req = 1'b0;
      apply(mk("LW 04 ignored", 1'b0, 3'b010, 6'h04, 32'h0, 1'b1, 1'b0, 32'h0));
      apply(mk("LW 10 cleared", 1'b0, 3'b010, 6'h10, 32'h0, 1'b1, 1'b0, 32'h0));
      apply(mk("LW 3C cleared", 1'b0, 3'b010, 6'h3C, 32'h0, 1'b1, 1'b0, 32'h0));

      // Non-clearing instance: store in the reset cycle is dropped, contents survive reset.
      drive(1'b1, 3'b010, 6'h20, 32'h0);
      rst0 = 1'b1;
      step();
      req = 1'b0;
      $display("[TB] dut0 reset -> ready=%0d rvalid=%0d err=%0d rdata=%08h", ready0, rvalid0, err0, rdata0);
      check("dut0 rst ready", 32'(ready0), 32'd0);
      check("dut0 rst rvalid", 32'(rvalid0), 32'd0);
      check("dut0 rst rdata", rdata0, 32'h0);
      step();
      rst0 = 1'b0;
      check("dut0 ready cyc0", 32'(ready0), 32'd0);
      step();
      check("dut0 ready cyc1", 32'(ready0), 32'd1);
      drive(1'b0, 3'b010, 6'h20, 32'h0);
      step();
      drive(1'b0, 3'b010, 6'h04, 32'h0);
      $display("[TB] dut0 LW 20 -> rvalid=%0d rdata=%08h", rvalid0, rdata0);
      check("dut0 LW 20 rvalid", 32'(rvalid0), 32'd1);
      check("dut0 LW 20 rdata", rdata0, 32'h12EE5678);
      step();
      req = 1'b0;
      $display("[TB] dut0 LW 04 -> rvalid=%0d rdata=%08h", rvalid0, rdata0);
      check("dut0 LW 04 rdata", rdata0, 32'hCAFEF00D);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
